// File: rtl/vram_read_arbiter.sv
// Arbitrates the single VRAM32 read port between the BGW and sprite renderers, with line-phase priority and sprite starvation override.
// Optional conflict statistics counter is built when VRAM_ARB_STATS_EN is defined.
module vram_read_arbiter #(
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        hblank,
  input  logic        bgw_req,
  input  logic [13:0] bgw_addr,
  output logic        bgw_gnt,
  output logic        bgw_valid,
  output logic [31:0] bgw_q,
  input  logic        spr_req,
  input  logic [13:0] spr_addr,
  output logic        spr_gnt,
  output logic        spr_valid,
  output logic [31:0] spr_q,
`ifdef VRAM_ARB_STATS_EN
  input  logic        stats_clr,
  output logic [15:0] conflict_cnt,
`endif
  output logic [13:0] vram_addr,
  input  logic [31:0] vram_q
);

  localparam int unsigned AW     = 14;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PIPE_D = RD_LAT + 1;
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);
  localparam bit               FORCE_EN = (STARVE_LIMIT != 0);

  typedef enum logic [1:0] {
    S_BGW_PRI   = 2'd0,
    S_SPR_PRI   = 2'd1,
    S_SPR_FORCE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic [AW-1:0]     vram_addr_q, vram_addr_d;
  logic [PIPE_D-1:0] bgw_tag_q, bgw_tag_d;
  logic [PIPE_D-1:0] spr_tag_q, spr_tag_d;
  logic              spr_denied;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_BGW_PRI;
      starve_cnt_q <= '0;
      vram_addr_q  <= '0;
      bgw_tag_q    <= '0;
      spr_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      vram_addr_q  <= vram_addr_d;
      bgw_tag_q    <= bgw_tag_d;
      spr_tag_q    <= spr_tag_d;
    end
  end

  // Grants are combinational in the request cycle and suppressed while reset is held.
  always_comb begin
    bgw_gnt = 1'b0;
    spr_gnt = 1'b0;
    if (!reset) begin
      case (state_q)
        S_SPR_PRI: begin
          spr_gnt = spr_req;
          bgw_gnt = bgw_req & ~spr_req;
        end
        S_SPR_FORCE: begin
          spr_gnt = spr_req;
          bgw_gnt = 1'b0;
        end
        default: begin
          bgw_gnt = bgw_req;
          spr_gnt = spr_req & ~bgw_req;
        end
      endcase
    end
  end

  always_comb begin
    state_d      = hblank ? S_SPR_PRI : S_BGW_PRI;
    starve_cnt_d = '0;
    vram_addr_d  = vram_addr_q;
    spr_denied   = spr_req & ~spr_gnt;

    // A sprite denied for STARVE_LIMIT cycles in a row wins the next one outright.
    if (FORCE_EN && (starve_cnt_q == LIMIT_M1) && spr_denied) begin
      state_d = S_SPR_FORCE;
    end

    if (spr_denied && (starve_cnt_q < LIMIT)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end else if (spr_denied) begin
      starve_cnt_d = starve_cnt_q;
    end

    if (bgw_gnt) begin
      vram_addr_d = bgw_addr;
    end else if (spr_gnt) begin
      vram_addr_d = spr_addr;
    end

    bgw_tag_d = {bgw_tag_q[PIPE_D-2:0], bgw_gnt};
    spr_tag_d = {spr_tag_q[PIPE_D-2:0], spr_gnt};
  end

  assign vram_addr = vram_addr_q;
  assign bgw_valid = bgw_tag_q[PIPE_D-1];
  assign spr_valid = spr_tag_q[PIPE_D-1];
  assign bgw_q     = vram_q;
  assign spr_q     = vram_q;

`ifdef VRAM_ARB_STATS_EN
  localparam int unsigned STAT_W = 16;

  logic [STAT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  // Saturating count of cycles where both renderers want the port; clear beats increment.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (stats_clr) begin
      conflict_cnt_d = '0;
    end else if (bgw_req && spr_req && (conflict_cnt_q != '1)) begin
      conflict_cnt_d = conflict_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      conflict_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_vram_read_arbiter.sv
// Directed bench for vram_read_arbiter (RD_LAT=1, STARVE_LIMIT=4) with a registered VRAM model.
// Statistics checks are built when VRAM_ARB_STATS_EN is defined.
module tb_vram_read_arbiter;

  logic        clk;
  logic        reset;
  logic        hblank;
  logic        bgw_req, spr_req;
  logic [13:0] bgw_addr, spr_addr;
  logic        bgw_gnt, bgw_valid, spr_gnt, spr_valid;
  logic [31:0] bgw_q, spr_q;
  logic [13:0] vram_addr;
  logic [31:0] vram_q;
`ifdef VRAM_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] conflict_cnt;
`endif

  int n_vec;
  int n_err;

  vram_read_arbiter #(
    .RD_LAT       (1),
    .STARVE_LIMIT (4)
  ) dut (
    .vga_clk      (clk),
    .reset        (reset),
    .hblank       (hblank),
    .bgw_req      (bgw_req),
    .bgw_addr     (bgw_addr),
    .bgw_gnt      (bgw_gnt),
    .bgw_valid    (bgw_valid),
    .bgw_q        (bgw_q),
    .spr_req      (spr_req),
    .spr_addr     (spr_addr),
    .spr_gnt      (spr_gnt),
    .spr_valid    (spr_valid),
    .spr_q        (spr_q),
`ifdef VRAM_ARB_STATS_EN
    .stats_clr    (stats_clr),
    .conflict_cnt (conflict_cnt),
`endif
    .vram_addr    (vram_addr),
    .vram_q       (vram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [13:0] a);
    return {4'hD, a ^ 14'h1555, a};
  endfunction

  // VRAM with one clock of read latency after the address is presented.
  always @(posedge clk) vram_q <= mem_f(vram_addr);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic exp_b, exp_s, prev_b, prev_s;

  initial begin
    n_vec    = 0;
    n_err    = 0;
    reset    = 1'b1;
    hblank   = 1'b0;
    bgw_req  = 1'b1;
    spr_req  = 1'b1;
    bgw_addr = 14'h0;
    spr_addr = 14'h0;
`ifdef VRAM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_bgw_gnt", 32'(bgw_gnt), 32'(0));
    check_val("rst_spr_gnt", 32'(spr_gnt), 32'(0));
    check_val("rst_bgw_vld", 32'(bgw_valid), 32'(0));
    check_val("rst_spr_vld", 32'(spr_valid), 32'(0));
    check_val("rst_addr", 32'(vram_addr), 32'(0));

    step();
    reset   = 1'b0;
    bgw_req = 1'b0;
    spr_req = 1'b0;

    // BGW streaming: 0x10 then 0x11 on consecutive cycles.
    step();
    bgw_req = 1'b1; bgw_addr = 14'h010;
    @(negedge clk);
    check_val("bs_gnt0", 32'(bgw_gnt), 32'(1));
    step();
    bgw_addr = 14'h011;
    @(negedge clk);
    check_val("bs_gnt1", 32'(bgw_gnt), 32'(1));
    check_val("bs_addr0", 32'(vram_addr), 32'(14'h010));
    step();
    bgw_req = 1'b0;
    @(negedge clk);
    check_val("bs_vld0", 32'(bgw_valid), 32'(1));
    check_val("bs_q0", bgw_q, mem_f(14'h010));
    check_val("bs_spr_vld0", 32'(spr_valid), 32'(0));
    check_val("bs_gnt_idle", 32'(bgw_gnt), 32'(0));
    step();
    @(negedge clk);
    check_val("bs_vld1", 32'(bgw_valid), 32'(1));
    check_val("bs_q1", bgw_q, mem_f(14'h011));
    step();
    @(negedge clk);
    check_val("bs_vld_end", 32'(bgw_valid), 32'(0));
    check_val("idle_addr_held", 32'(vram_addr), 32'(14'h011));

    // Contention in active video: four BGW grants, then a forced SPR grant.
    bgw_addr = 14'h040; spr_addr = 14'h200;
    prev_b = 1'b0; prev_s = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (prev_b) bgw_addr = bgw_addr + 14'd1;
      if (prev_s) spr_addr = spr_addr + 14'd1;
      bgw_req = (i < 10);
      spr_req = (i < 10);
      @(negedge clk);
      exp_s = (i < 10) && ((i % 5) == 4);
      exp_b = (i < 10) && !exp_s;
      check_val("ct_bgw_gnt", 32'(bgw_gnt), 32'(exp_b));
      check_val("ct_spr_gnt", 32'(spr_gnt), 32'(exp_s));
      check_val("ct_spr_vld", 32'(spr_valid), 32'((i == 6) || (i == 11)));
      check_val("ct_bgw_vld", 32'(bgw_valid), 32'((i >= 2) && (i < 12) && (((i - 2) % 5) != 4)));
      if (i == 2)  check_val("ct_bgw_q0", bgw_q, mem_f(14'h040));
      if (i == 6)  check_val("ct_spr_q0", spr_q, mem_f(14'h200));
      if (i == 11) check_val("ct_spr_q1", spr_q, mem_f(14'h201));
      prev_b = exp_b;
      prev_s = exp_s;
    end

    // hblank rise gives SPR priority one cycle later; fall returns it to BGW.
    step();
    bgw_req = 1'b1; spr_req = 1'b1; hblank = 1'b1;
    bgw_addr = 14'h0A0; spr_addr = 14'h0B0;
    @(negedge clk);
    check_val("hb_rise_bgw", 32'(bgw_gnt), 32'(1));
    check_val("hb_rise_spr", 32'(spr_gnt), 32'(0));
    step();
    @(negedge clk);
    check_val("hb_on_bgw", 32'(bgw_gnt), 32'(0));
    check_val("hb_on_spr", 32'(spr_gnt), 32'(1));
    step();
    hblank = 1'b0;
    @(negedge clk);
    check_val("hb_fall_spr", 32'(spr_gnt), 32'(1));
    step();
    @(negedge clk);
    check_val("hb_off_bgw", 32'(bgw_gnt), 32'(1));
    check_val("hb_off_spr", 32'(spr_gnt), 32'(0));
    step();
    bgw_req = 1'b0; spr_req = 1'b0;
    repeat (4) step();

    // Reset mid-cycle with reads in flight flushes them.
    bgw_req = 1'b1; bgw_addr = 14'h033;
    @(negedge clk);
    check_val("rf_bgw_gnt", 32'(bgw_gnt), 32'(1));
    step();
    bgw_req = 1'b0; spr_req = 1'b1; spr_addr = 14'h044;
    @(negedge clk);
    check_val("rf_spr_gnt", 32'(spr_gnt), 32'(1));
    check_val("rf_addr", 32'(vram_addr), 32'(14'h033));
    #2;
    reset = 1'b1;
    #1;
    check_val("rf_async_gnt", 32'(spr_gnt), 32'(0));
    check_val("rf_async_addr", 32'(vram_addr), 32'(0));
    check_val("rf_async_vld", 32'(bgw_valid), 32'(0));
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      check_val("rf_hold_bvld", 32'(bgw_valid), 32'(0));
      check_val("rf_hold_svld", 32'(spr_valid), 32'(0));
    end
    step();
    reset = 1'b0; spr_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("rf_post_bvld", 32'(bgw_valid), 32'(0));
      check_val("rf_post_svld", 32'(spr_valid), 32'(0));
      step();
    end
    bgw_req = 1'b1; bgw_addr = 14'h066;
    spr_req = 1'b1; spr_addr = 14'h055;
    @(negedge clk);
    check_val("pr_bgw_gnt", 32'(bgw_gnt), 32'(1));
    check_val("pr_spr_gnt", 32'(spr_gnt), 32'(0));
    step();
    bgw_req = 1'b0;
    @(negedge clk);
    check_val("pr_spr_gnt2", 32'(spr_gnt), 32'(1));
    step();
    spr_req = 1'b0;
    @(negedge clk);
    check_val("pr_bgw_vld", 32'(bgw_valid), 32'(1));
    check_val("pr_bgw_q", bgw_q, mem_f(14'h066));
    check_val("pr_spr_vld0", 32'(spr_valid), 32'(0));
    step();
    @(negedge clk);
    check_val("pr_spr_vld", 32'(spr_valid), 32'(1));
    check_val("pr_spr_q", spr_q, mem_f(14'h055));
    check_val("pr_bgw_vld0", 32'(bgw_valid), 32'(0));

`ifdef VRAM_ARB_STATS_EN
    step();
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    bgw_req = 1'b1; spr_req = 1'b1;
    repeat (10) step();
    bgw_req = 1'b0; spr_req = 1'b0;
    @(negedge clk);
    check_val("st_cnt10", 32'(conflict_cnt), 32'(10));
    step();
    stats_clr = 1'b1; bgw_req = 1'b1; spr_req = 1'b1;
    step();
    stats_clr = 1'b0; bgw_req = 1'b0; spr_req = 1'b0;
    @(negedge clk);
    check_val("st_clr_wins", 32'(conflict_cnt), 32'(0));
    step();
    bgw_req = 1'b1; spr_req = 1'b1;
    repeat (65534) step();
    bgw_req = 1'b0; spr_req = 1'b0;
    @(negedge clk);
    check_val("st_fffe", 32'(conflict_cnt), 32'(16'hFFFE));
    step();
    bgw_req = 1'b1; spr_req = 1'b1;
    repeat (3) step();
    bgw_req = 1'b0; spr_req = 1'b0;
    @(negedge clk);
    check_val("st_sat", 32'(conflict_cnt), 32'(16'hFFFF));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
